// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the sequential multiplier
//                and its ripple-carry adder datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Operand width, fixed to match the rca_8 adder
    localparam int OP_W       = 8;
    // Shift-and-add iterations per product
    localparam int ITER_COUNT = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/seq_mult_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_8_if
//  Description : Operand/product valid-ready bus of seq_mult_8. The master
//                supplies operands and consumes products; the slave is the
//                multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult_8_if;

    logic                         in_valid;
    logic                         in_ready;
    logic [mult_pkg::OP_W-1:0]    a;
    logic [mult_pkg::OP_W-1:0]    b;
    logic                         out_valid;
    logic                         out_ready;
    logic [2*mult_pkg::OP_W-1:0]  product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface : seq_mult_8_if
`default_nettype wire

// File: rtl/rca_8.sv
`default_nettype none
// ============================================================================
//  Module      : rca_8
//  Description : 8-bit combinational ripple-carry adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_8
    import mult_pkg::*;
(
    input  wire logic [OP_W-1:0] a_i,
    input  wire logic [OP_W-1:0] b_i,
    input  wire logic            cin_i,
    output logic      [OP_W-1:0] sum_o,
    output logic                 cout_o
);

    logic [OP_W:0] w_carry;

    assign w_carry[0] = cin_i;

    // One full adder per bit, carry rippling upward
    generate
        for (genvar i = 0; i < OP_W; i++) begin : g_fa
            assign sum_o[i]     = a_i[i] ^ b_i[i] ^ w_carry[i];
            assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign cout_o = w_carry[OP_W];

endmodule : rca_8
`default_nettype wire

// File: rtl/seq_mult_8.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_8
//  Description : Sequential 8x8 unsigned shift-and-add multiplier. One
//                iteration per cycle through rca_8; 16-bit product held in
//                DONE until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_8
    import mult_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    seq_mult_8_if.slave bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DONE   = DONE;
    localparam logic [2:0] CNT_LAST = 3'(ITER_COUNT - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q,   cnt_d;
    logic [OP_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0] hi_q,    hi_d;
    logic [OP_W-1:0] lo_q,    lo_d;

    logic [OP_W-1:0]   w_addend;
    logic [OP_W-1:0]   w_sum;
    logic              w_cout;
    logic [2*OP_W-1:0] w_shifted;

    // Add the multiplicand only when the current multiplier bit is set
    assign w_addend = lo_q[0] ? mcand_q : '0;

    rca_8 u_rca (
        .a_i    (hi_q),
        .b_i    (w_addend),
        .cin_i  (1'b0),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // {cout,sum,lo} >> 1: carry lands in hi[7], sum[0] shifts into lo[7]
    assign w_shifted = {w_cout, w_sum, lo_q[OP_W-1:1]};

    // Next-state and datapath update decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.a;
                    lo_d    = bus.b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                {hi_d, lo_d} = w_shifted;
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Handshake flags come straight from the state register
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.product   = {hi_q, lo_q};

endmodule : seq_mult_8
`default_nettype wire

// File: tb/tb_seq_mult_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_8
//  Description : Self-checking bench for seq_mult_8 against a plain a*b
//                reference with an in-order product scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_mult_8_if bus ();

    seq_mult_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every completed output handshake, in order
    logic [15:0] got_q[$];
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.product);
        end
    end

    // Present one operand pair, return cycles from accept to out_valid
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.a        = op_a;
        bus.b        = op_b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'hFF;
        bus.b         = 8'hFF;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b product=%h, required 1 0 0000",
                     bus.in_ready, bus.out_valid, bus.product);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        bus.out_ready = 1'b1;
        run_op(8'h0D, 8'h0B, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d, required 8", lat);
        end
        total++;
        if (bus.product !== 16'h008F || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_product: product=%h in_ready=%0b, required 008f 0", bus.product, bus.in_ready);
        end
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_return_idle: in_ready=%0b out_valid=%0b, required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [5] = '{8'hFF, 8'h00, 8'h5A, 8'h01, 8'h80};
        logic [7:0]  tb [5] = '{8'hFF, 8'hA5, 8'h00, 8'h80, 8'h01};
        logic [15:0] exp_p;
        int          lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_p = 16'(ta[i]) * 16'(tb[i]);
            run_op(ta[i], tb[i], lat);
            total++;
            if (bus.product !== exp_p || lat !== 8) begin
                bad++;
                $display("FAIL corner_%0d: %h*%h product=%h lat=%0d, required %h lat=8",
                         i, ta[i], tb[i], bus.product, lat, exp_p);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        run_op(8'h12, 8'h34, lat);
        total++;
        if (bus.product !== 16'h03A8) begin
            bad++;
            $display("FAIL bp_product: got %h, required 03a8", bus.product);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== 16'h03A8) begin
                bad++;
                $display("FAIL bp_hold_%0d: out_valid=%0b in_ready=%0b product=%h, required 1 0 03a8",
                         i, bus.out_valid, bus.in_ready, bus.product);
            end
            bus.in_valid = 1'($urandom);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
        end
        bus.in_valid  = 1'b0;
        got_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", bus.out_valid, bus.in_ready);
        end
        repeat (4) @(negedge clk);
        total++;
        if (got_q.size() !== 1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_handshake: handshakes=%0d out_valid=%0b, required 1 0",
                     got_q.size(), bus.out_valid);
        end else begin
            total++;
            if (got_q[0] !== 16'h03A8) begin
                bad++;
                $display("FAIL bp_handshake_value: got %h, required 03a8", got_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h77;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.product !== 16'h0000 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_run: out_valid=%0b product=%h in_ready=%0b, required 0 0000 1",
                     bus.out_valid, bus.product, bus.in_ready);
        end
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (got_q.size() !== 0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_abort: handshakes=%0d in_ready=%0b, required 0 1", got_q.size(), bus.in_ready);
        end
        run_op(8'h03, 8'h07, lat);
        total++;
        if (bus.product !== 16'h0015 || lat !== 8) begin
            bad++;
            $display("FAIL after_reset_op: product=%h lat=%0d, required 0015 lat=8", bus.product, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] exp_p;
        int          lat;
        int          stall;
        got_q.delete();
        for (int n = 0; n < 1000; n++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            exp_p = 16'(ra) * 16'(rb);
            exp_q.push_back(exp_p);
            bus.out_ready = 1'b0;
            run_op(ra, rb, lat);
            total++;
            if (bus.product !== exp_p || lat !== 8) begin
                bad++;
                $display("FAIL rand_%0d: %h*%h product=%h lat=%0d, required %h lat=8",
                         n, ra, rb, bus.product, lat, exp_p);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                total++;
                if (bus.out_valid !== 1'b1 || bus.product !== exp_p) begin
                    bad++;
                    $display("FAIL rand_stall_%0d: out_valid=%0b product=%h, required 1 %h",
                             n, bus.out_valid, bus.product, exp_p);
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rand_drain_%0d: out_valid=%0b, required 0", n, bus.out_valid);
            end
        end
        @(negedge clk);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: handshakes=%0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    total++;
                    bad++;
                    $display("FAIL rand_order_%0d: got %h, required %h", i, got_q[i], exp_q[i]);
                    break;
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_mult_8
`default_nettype wire
